// File: rtl/movimenta_aster.sv
// Asteroid mover: one read-modify-write sweep of the descriptor RAM per game tick.
// Optional MOVIMENTA_ASTER_PARA_COLISAO_EN: stop the sweep at the first collision.
module movimenta_aster #(
  parameter int unsigned N_MAX     = 16,
  parameter int unsigned LARG_ADDR = 4,
  parameter int unsigned CENTRO    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iniciar,
  input  logic [LARG_ADDR:0]   n_aster,
  output logic [LARG_ADDR-1:0] mem_addr,
  output logic                 mem_we,
  output logic [9:0]           mem_data,
  input  logic [9:0]           mem_q,
  output logic                 ocupado,
  output logic                 pronto,
  output logic                 colisao,
  output logic [LARG_ADDR-1:0] colisao_idx
);

  localparam int unsigned LARG_N = LARG_ADDR + 1;
  localparam int unsigned LARG_C = 4;
  localparam logic [LARG_C-1:0] CENTRO_C = LARG_C'(CENTRO);

  typedef enum logic [1:0] {OCIOSO, LE, ESCREVE, FIM} estado_t;

  estado_t              estado, estado_nx;
  logic [LARG_ADDR-1:0] idx, idx_nx;
  logic [LARG_N-1:0]    n_lat, n_lat_nx, n_clamp;
  logic [LARG_ADDR-1:0] mem_addr_nx, colisao_idx_nx;
  logic                 colisao_nx;
  logic [LARG_C-1:0]    x, y, x_nx, y_nx;
  logic [1:0]           dir;
  logic                 centro_rd, centro_wr, ultimo;

  assign x   = mem_q[9:6];
  assign y   = mem_q[5:2];
  assign dir = mem_q[1:0];

  // One cell step along dir; 4-bit wrap is intentional
  always_comb begin
    x_nx = x;
    y_nx = y;
    case (dir)
      2'b00:   x_nx = x + LARG_C'(1);
      2'b01:   x_nx = x - LARG_C'(1);
      2'b10:   y_nx = y + LARG_C'(1);
      default: y_nx = y - LARG_C'(1);
    endcase
  end

  assign centro_rd = (x == CENTRO_C) && (y == CENTRO_C);
  assign centro_wr = (x_nx == CENTRO_C) && (y_nx == CENTRO_C);
  assign n_clamp   = (n_aster > LARG_N'(N_MAX)) ? LARG_N'(N_MAX) : n_aster;
  assign ultimo    = ({1'b0, idx} == (n_lat - LARG_N'(1)));

  // Next-state and datapath; mem_we/mem_data follow mem_q in the same cycle
  always_comb begin
    estado_nx      = estado;
    idx_nx         = idx;
    n_lat_nx       = n_lat;
    mem_addr_nx    = mem_addr;
    colisao_nx     = colisao;
    colisao_idx_nx = colisao_idx;
    mem_we         = 1'b0;
    mem_data       = '0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          n_lat_nx       = n_clamp;
          idx_nx         = '0;
          colisao_nx     = 1'b0;
          colisao_idx_nx = '0;
          if (n_clamp != '0) begin
            estado_nx   = LE;
            mem_addr_nx = '0;
          end else begin
            estado_nx = FIM;
          end
        end
      end
      LE: estado_nx = ESCREVE;
      ESCREVE: begin
        if (!centro_rd) begin
          mem_we   = 1'b1;
          mem_data = {x_nx, y_nx, dir};
        end
        if (centro_rd || centro_wr) begin
          colisao_nx = 1'b1;
          if (!colisao) colisao_idx_nx = idx;
        end
`ifdef MOVIMENTA_ASTER_PARA_COLISAO_EN
        if (ultimo || centro_rd || centro_wr) begin
`else
        if (ultimo) begin
`endif
          estado_nx = FIM;
        end else begin
          idx_nx      = idx + LARG_ADDR'(1);
          mem_addr_nx = idx + LARG_ADDR'(1);
          estado_nx   = LE;
        end
      end
      default: estado_nx = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      idx         <= '0;
      n_lat       <= '0;
      mem_addr    <= '0;
      colisao     <= 1'b0;
      colisao_idx <= '0;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      estado      <= estado_nx;
      idx         <= idx_nx;
      n_lat       <= n_lat_nx;
      mem_addr    <= mem_addr_nx;
      colisao     <= colisao_nx;
      colisao_idx <= colisao_idx_nx;
      ocupado     <= (estado_nx != OCIOSO);
      pronto      <= (estado_nx == FIM);
    end
  end

endmodule

// File: tb/tb_movimenta_aster.sv
// Randomised bench for movimenta_aster against a sweep-level model of the asteroid RAM.
module tb_movimenta_aster;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iniciar;
  logic [4:0] n_aster;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [9:0] mem_data;
  logic [9:0] mem_q;
  logic       ocupado, pronto, colisao;
  logic [3:0] colisao_idx;

  logic [9:0] ram [16];
  logic [9:0] img [16];
  logic       ld_en;
  logic [3:0] ld_addr;
  logic [9:0] ld_data;
  int         n_wr = 0;
  int         errors = 0;
  int         checks = 0;

  movimenta_aster dut (
    .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .n_aster(n_aster),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_data(mem_data), .mem_q(mem_q),
    .ocupado(ocupado), .pronto(pronto), .colisao(colisao), .colisao_idx(colisao_idx)
  );

  always #5 clk = ~clk;

  // Asteroid RAM with registered read, plus a bench load port
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (mem_we) begin
      ram[mem_addr] <= mem_data;
      n_wr <= n_wr + 1;
    end
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic load_img();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 4'(i); ld_data = img[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  function automatic logic [9:0] step(input logic [9:0] e);
    int xi, yi;
    xi = int'(e[9:6]);
    yi = int'(e[5:2]);
    case (e[1:0])
      2'd0: xi = (xi + 1) % 16;
      2'd1: xi = (xi + 15) % 16;
      2'd2: yi = (yi + 1) % 16;
      default: yi = (yi + 15) % 16;
    endcase
    return {4'(xi), 4'(yi), e[1:0]};
  endfunction

  // Sweep with model prediction; extra=1 adds an ignored iniciar mid-sweep
  task automatic sweep(input int n, input bit extra);
    logic [9:0] exp_ram [16];
    int nc, swept, writes, cidx, cyc, wr0;
    bit col, hit;
    nc = (n > 16) ? 16 : n;
    col = 0; cidx = 0; swept = 0; writes = 0;
    for (int i = 0; i < 16; i++) exp_ram[i] = ram[i];
    for (int i = 0; i < nc; i++) begin
      if (exp_ram[i] == {4'd7, 4'd7, exp_ram[i][1:0]}) hit = 1;
      else begin
        exp_ram[i] = step(exp_ram[i]);
        writes++;
        hit = (exp_ram[i][9:2] == {4'd7, 4'd7});
      end
      swept++;
      if (hit && !col) begin col = 1; cidx = i; end
`ifdef MOVIMENTA_ASTER_PARA_COLISAO_EN
      if (hit) break;
`endif
    end
    wr0 = n_wr;
    @(negedge clk);
    n_aster = 5'(n); iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    cyc = 1;
    chk("ocupado_c1", int'(ocupado), 1);
    if (extra) begin iniciar = 1'b1; n_aster = 5'd3; end
    while (pronto !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      iniciar = 1'b0;
      cyc++;
    end
    chk("pronto_cycle", cyc, 2 * swept + 1);
    chk("colisao", int'(colisao), int'(col));
    chk("colisao_idx", int'(colisao_idx), cidx);
    @(negedge clk);
    iniciar = 1'b0;
    chk("pronto_pulse", int'(pronto), 0);
    @(negedge clk);
    chk("idle", int'(ocupado), 0);
    chk("colisao_hold", int'(colisao), int'(col));
    chk("writes", n_wr - wr0, writes);
    for (int i = 0; i < 16; i++) chk($sformatf("ram%0d", i), int'(ram[i]), int'(exp_ram[i]));
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img[i] = '0;
  endtask

  initial begin
    int tmo;
    rst_n = 1'b0; iniciar = 1'b0; n_aster = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #1;
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_we", int'(mem_we), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_colisao", int'(colisao), 0);
    chk("rst_cidx", int'(colisao_idx), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic two-entry move
    clear_img();
    img[0] = 10'b0111_0000_10; img[1] = 10'b0000_0111_00;
    load_img();
    sweep(2, 0);
    chk("t1_e0", int'(ram[0]), int'(10'b0111_0001_10));
    chk("t1_e1", int'(ram[1]), int'(10'b0001_0111_00));

    // Already at centre: no write, collision
    clear_img();
    img[4] = 10'b0111_0111_00;
    load_img();
    sweep(5, 0);
    chk("t2_col", int'(colisao), 1);
    chk("t2_idx", int'(colisao_idx), 4);
    chk("t2_e4", int'(ram[4]), int'(10'b0111_0111_00));

    // Two entries reach the centre
    clear_img();
    img[2] = 10'b0110_0111_00; img[3] = 10'b1000_0111_01;
    load_img();
    sweep(4, 0);
    chk("t3_e2", int'(ram[2]), int'(10'b0111_0111_00));
    chk("t3_idx", int'(colisao_idx), 2);
`ifdef MOVIMENTA_ASTER_PARA_COLISAO_EN
    chk("t3_e3", int'(ram[3]), int'(10'b1000_0111_01));
`else
    chk("t3_e3", int'(ram[3]), int'(10'b0111_0111_01));
`endif

    // Empty sweep with a second iniciar while busy, then a busy pulse mid-sweep
    sweep(0, 1);
    sweep(3, 1);

    // Wrap
    clear_img();
    img[0] = 10'b1111_0011_00;
    load_img();
    sweep(1, 0);
    chk("t5_e0", int'(ram[0]), int'(10'b0000_0011_00));
    chk("t5_col", int'(colisao), 0);

    // Reset during ESCREVE of index 1 after entry 0 collided
    clear_img();
    img[0] = 10'b0111_0111_10;
    for (int i = 1; i < 16; i++) img[i] = 10'b0001_0001_00;
    load_img();
    @(negedge clk);
    n_aster = 5'd4; iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    tmo = 0;
    while (!(mem_we === 1'b1 && mem_addr == 4'd1) && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    chk("rst_reach", int'(tmo < 20), 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_we", int'(mem_we), 0);
    chk("mrst_ocupado", int'(ocupado), 0);
    chk("mrst_colisao", int'(colisao), 0);
    chk("mrst_addr", int'(mem_addr), 0);
    chk("mrst_e1", int'(ram[1]), int'(10'b0001_0001_00));
    @(negedge clk);
    rst_n = 1'b1;
    sweep(4, 0);
    chk("mrst_idx0", int'(colisao_idx), 0);

    // Randomised sweeps, positions biased toward the centre
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 2) == 0)
          img[i] = {4'($urandom_range(6, 8)), 4'($urandom_range(6, 8)), 2'($urandom_range(0, 3))};
        else
          img[i] = 10'($urandom);
      end
      load_img();
      sweep(int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/movimenta_aster.md
Name: movimenta_aster

Overview:
- Sweeps the 16-entry asteroid descriptor RAM once per game tick and advances every active asteroid one cell toward the screen centre.
- Performs read-modify-write: each entry is read, its position is stepped along its direction, and the result is written back.
- Flags a collision when an asteroid is at, or reaches, the centre.
- Sits between the game-control FSM, which pulses iniciar per tick, and the asteroid RAM, whose read address is registered and whose q is valid the cycle after the address is presented.

Parameters:
- N_MAX, 16, number of RAM entries; also the maximum legal n_aster.
- LARG_ADDR, 4, RAM address width.
- CENTRO, 7, centre coordinate on both axes.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iniciar  in  1  one-cycle pulse; starts a sweep.
- n_aster  in  5  number of active entries, 0..16; sampled on the iniciar edge.
- mem_addr  out  4  RAM address.
- mem_we  out  1  RAM write enable.
- mem_data  out  10  RAM write data.
- mem_q  in  10  RAM read data, valid one cycle after mem_addr.
- ocupado  out  1  high while a sweep is in progress.
- pronto  out  1  one-cycle pulse at the end of a sweep.
- colisao  out  1  sticky per sweep: some asteroid is at the centre.
- colisao_idx  out  4  lowest index found at the centre in this sweep.

Behaviour:
- Descriptor layout: [9:6] x, [5:2] y, [1:0] dir.
- dir encoding: 00 gives x+1; 01 gives x-1; 10 gives y+1; 11 gives y-1. Arithmetic is 4-bit and wraps mod 16; there is no saturation.
- Reset values: all outputs 0; state OCIOSO; internal index 0; n_aster latch 0.
- FSM states: OCIOSO, LE, ESCREVE, FIM.
- OCIOSO:
  - On iniciar, latch n_aster, clear colisao and colisao_idx, set index=0.
  - Go to LE if n_aster is nonzero, otherwise go to FIM.
  - iniciar while ocupado=1 is ignored.
- LE (1 cycle):
  - mem_addr=index, mem_we=0.
  - Go to ESCREVE.
- ESCREVE (1 cycle):
  - mem_q is valid and mem_addr is held at index.
  - If x=CENTRO and y=CENTRO on read: mem_we=0, entry unchanged, collision recorded.
  - Otherwise: mem_we=1, mem_data={x',y',dir}. If the new position equals (CENTRO,CENTRO), record a collision.
  - Recording a collision: colisao<=1; colisao_idx<=index only if colisao was 0 (lowest index wins).
  - Then, if index=latched n_aster-1, go to FIM; else index+1 and go to LE.
- FIM (1 cycle):
  - pronto=1, mem_we=0.
  - Go to OCIOSO.
- ocupado is 1 in LE, ESCREVE and FIM.
- colisao and colisao_idx hold their values until the next iniciar.
- Latency: iniciar sampled at edge E0 gives pronto high in cycle 2·n+1 after E0. For n=0, pronto is high in the cycle after E0.
- mem_addr holds its last value when idle; mem_we is never asserted outside ESCREVE.
- n_aster values above 16 are clamped to 16.
- rst_n low mid-sweep: immediate return to reset values, no write in progress. A partially swept RAM is acceptable.

Optional Feature:
- Macro: MOVIMENTA_ASTER_PARA_COLISAO_EN.
- Defined: the first collision found ends the sweep. ESCREVE still performs that entry's write-back, then goes to FIM; higher entries are not moved.
- Undefined: all n entries are always swept. colisao_idx reports the lowest colliding index.

Test Plan:
- Reset mid-sweep (rst_n low during ESCREVE) -> outputs 0 the same cycle, no mem_we, and the next iniciar sweeps from index 0.
- RAM entry0=0111_0000_10, entry1=0000_0111_00, n_aster=2, pulse iniciar -> entry0=0111_0001_10 and entry1=0001_0111_00 written; pronto in cycle 5; colisao=0.
- n_aster=5, entry4=0111_0111_00 -> entry4 not written (mem_we=0 at addr 4); colisao=1, colisao_idx=4.
- entry2=0110_0111_00, entry3=1000_0111_01, n_aster=4 -> entry2 becomes 0111_0111_00 and entry3 becomes 0111_0111_01; colisao_idx=2. With the macro defined, entry3 stays unchanged and pronto comes in cycle 7.
- n_aster=0 -> pronto in cycle 1, mem_we never asserted; a second iniciar while ocupado=1 has no effect.
- Wrap check: entry0=1111_0011_00 -> written 0000_0011_00, no collision.
